// File: rtl/mux_n_1_stream.sv
// mux_n_1_stream
//   Selects one of N input channels through WIDTH/SLICE narrow slice muxes.
//   The selected word and its channel index are buffered in a 2-entry FIFO
//   with valid/ready handshakes on both sides.
//
// Parameters
//   WIDTH  data width per channel (multiple of SLICE, >= 2)
//   N      number of input channels (2..16)
//   SLICE  width of each slice mux
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active high
//   up_valid     upstream offers a word
//   up_ready     block accepts a word (depends only on registered state)
//   up_sel       channel index; values >= N select an all-zero word
//   up_data      channel i at [i*WIDTH +: WIDTH]
//   down_valid   oldest FIFO entry is available
//   down_ready   downstream accepts the word
//   down_data    oldest buffered word
//   down_sel     channel index that produced down_data
//   down_parity  XOR of down_data, stored with the entry
//                (port exists only when MUX_PARITY_EN is defined)
//
// Build option
//   MUX_PARITY_EN  adds the down_parity port and per-entry parity storage.
module mux_n_1_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SLICE = 2,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic [SW-1:0]        up_sel,
    input  logic [N*WIDTH-1:0]   up_data,
    output logic                 down_valid,
    input  logic                 down_ready,
    output logic [WIDTH-1:0]     down_data,
    output logic [SW-1:0]        down_sel
`ifdef MUX_PARITY_EN
    ,
    output logic                 down_parity
`endif
);

    localparam int NSLICE = WIDTH / SLICE;

    logic [WIDTH-1:0] w_mux_data;

    // Each slice mux defaults to zero, so an out-of-range up_sel yields an
    // all-zero word without a separate range check.
    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
        logic [SLICE-1:0] w_slice;

        always_comb begin
            w_slice = '0;
            for (int unsigned i = 0; i < N; i++) begin
                if (up_sel == SW'(i)) begin
                    w_slice = up_data[i*WIDTH + g*SLICE +: SLICE];
                end
            end
        end

        assign w_mux_data[g*SLICE +: SLICE] = w_slice;
    end

    logic [WIDTH-1:0] r_mem_data [2];
    logic [SW-1:0]    r_mem_sel  [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic w_push;
    logic w_pop;

    assign up_ready   = (r_count != 2'd2);
    assign down_valid = (r_count != 2'd0);
    assign w_push     = up_valid && up_ready;
    assign w_pop      = down_valid && down_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem_data[i] <= '0;
                r_mem_sel[i]  <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_data[r_wptr] <= w_mux_data;
                r_mem_sel[r_wptr]  <= up_sel;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign down_data = r_mem_data[r_rptr];
    assign down_sel  = r_mem_sel[r_rptr];

`ifdef MUX_PARITY_EN
    logic r_mem_par [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem_par[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_mem_par[r_wptr] <= ^w_mux_data;
        end
    end

    assign down_parity = r_mem_par[r_rptr];
`endif

endmodule

// File: tb/tb_mux_n_1_stream.sv
// tb_mux_n_1_stream
//   Directed bench for mux_n_1_stream: a WIDTH=8/N=4 instance for the main
//   stream, backpressure and reset scenarios, and a WIDTH=8/N=3 instance
//   for the out-of-range select case. Inputs change on the falling edge and
//   outputs are checked there, half a cycle after each rising edge.
module tb_mux_n_1_stream;

    logic        clk = 1'b0;
    logic        rst;

    logic        up_valid;
    logic        up_ready;
    logic [1:0]  up_sel;
    logic [31:0] up_data;
    logic        down_valid;
    logic        down_ready;
    logic [7:0]  down_data;
    logic [1:0]  down_sel;

    logic        up_valid3;
    logic        up_ready3;
    logic [1:0]  up_sel3;
    logic [23:0] up_data3;
    logic        down_valid3;
    logic        down_ready3;
    logic [7:0]  down_data3;
    logic [1:0]  down_sel3;

`ifdef MUX_PARITY_EN
    logic        down_parity;
    logic        down_parity3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_n_1_stream #(.WIDTH(8), .N(4), .SLICE(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_sel     (up_sel),
        .up_data    (up_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .down_sel   (down_sel)
`ifdef MUX_PARITY_EN
        ,
        .down_parity(down_parity)
`endif
    );

    mux_n_1_stream #(.WIDTH(8), .N(3), .SLICE(2)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid3),
        .up_ready   (up_ready3),
        .up_sel     (up_sel3),
        .up_data    (up_data3),
        .down_valid (down_valid3),
        .down_ready (down_ready3),
        .down_data  (down_data3),
        .down_sel   (down_sel3)
`ifdef MUX_PARITY_EN
        ,
        .down_parity(down_parity3)
`endif
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; up_valid = 1'b1; up_sel = 2'd1; up_data = 32'hD3C2B1A0;
        down_ready = 1'b0;
        up_valid3 = 1'b1; up_sel3 = 2'd0; up_data3 = 24'hC2B1A0; down_ready3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; up_valid = 1'b0; up_valid3 = 1'b0;
        n_checks++; if (down_valid !== 1'b0) begin n_fail++; $display("FAIL reset_down_valid got %b want 0", down_valid); end
        n_checks++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL reset_up_ready got %b want 1", up_ready); end
        n_checks++; if (down_data !== 8'h00) begin n_fail++; $display("FAIL reset_down_data got %h want 00", down_data); end
        n_checks++; if (down_sel !== 2'd0) begin n_fail++; $display("FAIL reset_down_sel got %0d want 0", down_sel); end
        n_checks++; if (down_valid3 !== 1'b0) begin n_fail++; $display("FAIL reset_down_valid3 got %b want 0", down_valid3); end
`ifdef MUX_PARITY_EN
        n_checks++; if (down_parity !== 1'b0) begin n_fail++; $display("FAIL reset_down_parity got %b want 0", down_parity); end
`endif
        @(negedge clk);
        n_checks++; if (down_valid !== 1'b0) begin n_fail++; $display("FAIL idle_down_valid got %b want 0", down_valid); end
        n_checks++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL idle_up_ready got %b want 1", up_ready); end
    endtask

    task automatic test_stream();
        logic [7:0] exp_data [4];
        exp_data[0] = 8'hA0; exp_data[1] = 8'hB1; exp_data[2] = 8'hC2; exp_data[3] = 8'hD3;
        up_data = 32'hD3C2B1A0; down_ready = 1'b1;
        up_valid = 1'b1; up_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (down_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b want 1", i, down_valid); end
            n_checks++; if (down_data !== exp_data[i]) begin n_fail++; $display("FAIL stream_data[%0d] got %h want %h", i, down_data, exp_data[i]); end
            n_checks++; if (down_sel !== 2'(i)) begin n_fail++; $display("FAIL stream_sel[%0d] got %0d want %0d", i, down_sel, i); end
            n_checks++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL stream_up_ready[%0d] got %b want 1", i, up_ready); end
            if (i < 3) up_sel = 2'(i + 1);
            else up_valid = 1'b0;
        end
        @(negedge clk);
        n_checks++; if (down_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b want 0", down_valid); end
    endtask

    task automatic test_out_of_range();
        up_data3 = 24'hC2B1A0; down_ready3 = 1'b0;
        up_valid3 = 1'b1; up_sel3 = 2'd3;
        @(negedge clk);
        up_valid3 = 1'b0; up_sel3 = 2'd0;
        n_checks++; if (down_valid3 !== 1'b1) begin n_fail++; $display("FAIL oob_valid got %b want 1", down_valid3); end
        n_checks++; if (down_data3 !== 8'h00) begin n_fail++; $display("FAIL oob_data got %h want 00", down_data3); end
        n_checks++; if (down_sel3 !== 2'd3) begin n_fail++; $display("FAIL oob_sel got %0d want 3", down_sel3); end
        @(negedge clk);
        n_checks++; if (down_sel3 !== 2'd3) begin n_fail++; $display("FAIL oob_hold_sel got %0d want 3", down_sel3); end
        down_ready3 = 1'b1;
        @(negedge clk);
        n_checks++; if (down_valid3 !== 1'b0) begin n_fail++; $display("FAIL oob_drain got %b want 0", down_valid3); end
        up_valid3 = 1'b1; up_sel3 = 2'd2;
        @(negedge clk);
        up_valid3 = 1'b0;
        n_checks++; if (down_data3 !== 8'hC2) begin n_fail++; $display("FAIL last_chan_data got %h want c2", down_data3); end
        n_checks++; if (down_sel3 !== 2'd2) begin n_fail++; $display("FAIL last_chan_sel got %0d want 2", down_sel3); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int seen;
        seen = 0;
        up_data = 32'hD3C2B1A0; down_ready = 1'b0;
        up_valid = 1'b1; up_sel = 2'd0;
        @(negedge clk);
        n_checks++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after1 got %b want 1", up_ready); end
        n_checks++; if (down_data !== 8'hA0) begin n_fail++; $display("FAIL bp_head1 got %h want a0", down_data); end
        up_sel = 2'd1;
        @(negedge clk);
        n_checks++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b want 0", up_ready); end
        up_sel = 2'd2;
        @(negedge clk);
        n_checks++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL bp_third_blocked got %b want 0", up_ready); end
        n_checks++; if (down_data !== 8'hA0 || down_sel !== 2'd0) begin n_fail++; $display("FAIL bp_stable got %h/%0d want a0/0", down_data, down_sel); end
        down_ready = 1'b1;
        @(negedge clk);
        seen++;
        n_checks++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return got %b want 1", up_ready); end
        n_checks++; if (down_data !== 8'hB1 || down_sel !== 2'd1) begin n_fail++; $display("FAIL bp_second got %h/%0d want b1/1", down_data, down_sel); end
        @(negedge clk);
        seen++;
        up_valid = 1'b0;
        n_checks++; if (down_valid !== 1'b1 || down_data !== 8'hC2 || down_sel !== 2'd2) begin n_fail++; $display("FAIL bp_third got %b/%h/%0d want 1/c2/2", down_valid, down_data, down_sel); end
        @(negedge clk);
        seen++;
        n_checks++; if (down_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got %b want 0 after %0d words", down_valid, seen); end
    endtask

    task automatic test_midstream_reset();
        up_data = 32'hD3C2B1A0; down_ready = 1'b0;
        up_valid = 1'b1; up_sel = 2'd0;
        @(negedge clk);
        up_sel = 2'd1;
        @(negedge clk);
        n_checks++; if (up_ready !== 1'b0) begin n_fail++; $display("FAIL mr_full got %b want 0", up_ready); end
        up_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; down_ready = 1'b1;
        n_checks++; if (down_valid !== 1'b0) begin n_fail++; $display("FAIL mr_valid got %b want 0", down_valid); end
        n_checks++; if (up_ready !== 1'b1 || down_data !== 8'h00) begin n_fail++; $display("FAIL mr_state got %b/%h want 1/00", up_ready, down_data); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (down_valid !== 1'b0) begin n_fail++; $display("FAIL mr_ghost[%0d] got %b want 0", i, down_valid); end
        end
    endtask

`ifdef MUX_PARITY_EN
    task automatic test_parity();
        up_data = 32'hD3C2B1A1; down_ready = 1'b1;
        up_valid = 1'b1; up_sel = 2'd1;
        @(negedge clk);
        up_sel = 2'd0;
        n_checks++; if (down_data !== 8'hB1 || down_parity !== 1'b0) begin n_fail++; $display("FAIL parity_b1 got %h/%b want b1/0", down_data, down_parity); end
        @(negedge clk);
        up_valid = 1'b0;
        n_checks++; if (down_data !== 8'hA1 || down_parity !== 1'b1) begin n_fail++; $display("FAIL parity_a1 got %h/%b want a1/1", down_data, down_parity); end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b0; up_valid = 1'b0; up_sel = '0; up_data = '0; down_ready = 1'b0;
        up_valid3 = 1'b0; up_sel3 = '0; up_data3 = '0; down_ready3 = 1'b0;
        test_reset();
        test_stream();
        test_out_of_range();
        test_backpressure();
        test_midstream_reset();
`ifdef MUX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mux_n_1_stream.md
MUX_N_1_STREAM -- requirements
Module: mux_n_1_stream

Interface
REQ-001 Parameter WIDTH, default 8: data width per channel, a multiple of SLICE, at least 2.
REQ-002 Parameter N, default 4: number of input channels, 2..16, not necessarily a power of two.
REQ-003 Parameter SLICE, default 2: width of each narrow slice mux in the datapath.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous reset, active high.
REQ-007 Port up_valid, input, 1 bit: upstream offers a word.
REQ-008 Port up_ready, output, 1 bit: block accepts a word this cycle.
REQ-009 Port up_sel, input, SW = max(1, $clog2(N)) bits: channel index.
REQ-010 Port up_data, input, N*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-011 Port down_valid, output, 1 bit: output word available.
REQ-012 Port down_ready, input, 1 bit: downstream accepts the word.
REQ-013 Port down_data, output, WIDTH bits: selected word.
REQ-014 Port down_sel, output, SW bits: channel index that produced down_data.
REQ-015 Port down_parity, output, 1 bit: present only when MUX_PARITY_EN is defined.

Function
REQ-016 The selection datapath SHALL consist of WIDTH/SLICE generated slice muxes, each N-to-1 and SLICE bits wide, sharing up_sel; their outputs are concatenated with slice 0 in the LSBs.
REQ-017 If up_sel >= N, the selected word SHALL be all zeros; the transfer still occurs and down_sel echoes the raw up_sel.
REQ-018 Handshake: an upstream transfer occurs when up_valid and up_ready are both 1 on a clock edge. A downstream transfer occurs when down_valid and down_ready are both 1 on a clock edge.
REQ-019 The block SHALL contain a 2-entry FIFO holding {sel, data}. Each upstream transfer writes the muxed word and up_sel into the FIFO.
REQ-020 up_ready SHALL be 1 exactly when the FIFO holds fewer than 2 entries, and SHALL be driven from registers only, with no combinational path from down_ready or up_valid.
REQ-021 down_valid SHALL be 1 exactly when the FIFO holds at least 1 entry. down_data and down_sel SHALL show the oldest entry.
REQ-022 Latency: a word transferred at edge k SHALL appear on down_valid/down_data after edge k, provided the FIFO was empty.
REQ-023 Throughput: with up_valid = 1 and down_ready = 1 held, one word SHALL transfer per cycle in each direction indefinitely.
REQ-024 Simultaneous push and pop with 1 entry held: the count stays at 1, and the new word becomes head in the next cycle.
REQ-025 With the FIFO full, up_ready = 0. A pop on that cycle drops the count to 1, and up_ready rises the next cycle.
REQ-026 While down_valid = 1 and down_ready = 0, down_data and down_sel SHALL remain stable.
REQ-027 Data and sel values are don't-care whenever up_valid = 0; they SHALL NOT alter state.

Reset
REQ-028 While rst = 1 at an edge: FIFO count = 0, pointers = 0, down_valid = 0, up_ready = 1 after the edge, down_data = 0, down_sel = 0, down_parity = 0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries; no word accepted before reset is emitted after it.
REQ-030 During the reset cycle, up_valid SHALL be ignored.

Configuration
REQ-031 With macro MUX_PARITY_EN defined: port down_parity exists and equals the XOR-reduction of down_data, stored in the FIFO alongside the data, not recomputed at the output.
REQ-032 Without MUX_PARITY_EN: no down_parity port and no parity storage; all other behaviour is identical.

Verification
REQ-033 Reset then idle: rst = 1 for 2 cycles, then low → down_valid = 0, up_ready = 1, down_data = 0.
REQ-034 WIDTH = 8, N = 4: up_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0}, sel 0..3 streamed with down_ready = 1 → outputs A0, B1, C2, D3, one cycle later each, with down_sel 0..3.
REQ-035 N = 3, up_sel = 3 → down_data = 8'h00, down_sel = 3.
REQ-036 Backpressure: down_ready = 0, push 3 words → the first 2 are accepted and up_ready = 0 on the third. Then down_ready = 1 → words emerge in order, none lost or duplicated, and the third is accepted after up_ready returns to 1.
REQ-037 Mid-stream reset: 2 entries buffered, rst = 1 for one cycle → down_valid = 0 on the next cycle, and the buffered words never appear.
REQ-038 MUX_PARITY_EN defined: selected word 8'hB1 → down_parity = 0; 8'hA1 → down_parity = 1.
